logic_sweep: RTL and testbench

LOGIC_SWEEP -- requirements
Module: logic_sweep

---
 rtl/logic_sweep.sv | 123 ++++++++++++
 tb/tb_logic_sweep.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_sweep.sv
// logic_sweep: applies a 4-bit truth-table code to an external 2-input
// logical unit, sweeps all four operand combinations, captures the unit's
// responses and reports whether they match the requested code. Mismatching
// results that the consumer accepts are tallied in a saturating counter.
module logic_sweep (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_func,
  output logic [3:0] func,
  output logic       a,
  output logic       b,
  input  logic       lu_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_bits,
  output logic       res_match,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_idx;
  logic [3:0] r_func;
  logic       r_a;
  logic       r_b;
  logic [3:0] r_res_bits;
  logic       r_cmd_ready;
  logic       r_res_valid;
  logic [7:0] r_err_count;

  logic [1:0] w_next_idx;
  logic       w_match;

  assign w_next_idx = r_idx + 2'd1;

  // Plain comparison of the captured bits against the applied code; it is
  // deliberately not gated by res_valid so it reads 1 straight out of reset.
  assign w_match = (r_res_bits == r_func);

  // Sweep controller: command intake, operand stepping, result capture and
  // error tally, all with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= 2'd0;
      r_func      <= 4'd0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_res_bits  <= 4'd0;
      r_cmd_ready <= 1'b1;
      r_res_valid <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge value of r_idx/r_state, regardless of statement order.
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_func      <= cmd_func;
            r_res_bits  <= 4'd0;
            r_idx       <= 2'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_state     <= SWEEP;
          end
        end

        SWEEP: begin
          // lu_out is only ever looked at here, so its value in other
          // states cannot disturb the controller.
          r_res_bits[r_idx] <= lu_out;
          r_idx             <= w_next_idx;
          if (r_idx == 2'd3) begin
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_a <= w_next_idx[1];
            r_b <= w_next_idx[0];
          end
        end

        DONE: begin
          // Returning to IDLE (not straight to SWEEP) keeps a pending
          // command waiting one extra edge after the result is taken.
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
            if (!w_match && (r_err_count != 8'hFF)) begin
              r_err_count <= r_err_count + 8'd1;
            end
          end
        end

        default: begin
          r_res_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign func      = r_func;
  assign a         = r_a;
  assign b         = r_b;
  assign res_valid = r_res_valid;
  assign res_bits  = r_res_bits;
  assign res_match = w_match;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_logic_sweep.sv
// tb_logic_sweep: directed stimulus against logic_sweep with an attached
// behavioural logical unit. Expected results are queued when a command is
// issued; a monitor pops and compares them whenever a result is handed over.
module tb_logic_sweep;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_func;
  logic [3:0] func;
  logic       a;
  logic       b;
  logic       lu_out;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_bits;
  logic       res_match;
  logic [7:0] err_count;

  logic       lu_force;   // 1: logical unit output stuck at 1 (fault)
  int         n_checks;
  int         n_fail;
  int         exp_err;

  typedef struct packed {
    logic [3:0] bits;
    logic       match;
    logic [7:0] err;
  } exp_t;

  exp_t sb_q[$];

  logic_sweep dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_func  (cmd_func),
    .func      (func),
    .a         (a),
    .b         (b),
    .lu_out    (lu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_bits  (res_bits),
    .res_match (res_match),
    .err_count (err_count)
  );

  // Downstream logical unit: a truth-table lookup indexed by {a,b}.
  logic [1:0] lu_sel;
  assign lu_sel = {a, b};
  assign lu_out = lu_force ? 1'b1 : func[lu_sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a result is handed over on the edge following a
  // falling edge that sees res_valid && res_ready.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      check("sb_result_expected", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_res_bits", 32'(res_bits), 32'(e.bits));
        check("sb_res_match", 32'(res_match), 32'(e.match));
        check("sb_err_before_accept", 32'(err_count), 32'(e.err));
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_func"}, 32'(func), 32'd0);
    check({tag, "_ab"}, 32'({a, b}), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_bits"}, 32'(res_bits), 32'd0);
    check({tag, "_res_match"}, 32'(res_match), 32'd1);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  // Wait for IDLE, present a command and leave just after its accept edge.
  task automatic issue(input logic [3:0] code, input logic [3:0] exp_bits,
                       input bit push);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_func  = code;
    if (push) sb_q.push_back({exp_bits, exp_bits == code, exp_err[7:0]});
    tick();
    cmd_valid = 1'b0;
  endtask

  // Called just after the accept edge; walks the four SWEEP cycles.
  task automatic sweep_steps(input logic [3:0] code, input logic [3:0] exp_bits);
    check("func_latched", 32'(func), 32'(code));
    check("cmd_ready_sweep", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("sweep_ab", 32'({a, b}), 32'(i));
      check("sweep_res_valid", 32'(res_valid), 32'd0);
      tick();
    end
    check("done_res_valid", 32'(res_valid), 32'd1);
    check("done_ab", 32'({a, b}), 32'd0);
    check("done_res_bits", 32'(res_bits), 32'(exp_bits));
  endtask

  // Let the result be taken (res_ready assumed high) and check the tally.
  task automatic accept_result(input bit exp_match);
    int n;
    n = 0;
    while (res_valid && n < 50) begin
      tick();
      n++;
    end
    check("result_taken", 32'(res_valid), 32'd0);
    if (!exp_match && exp_err != 255) exp_err++;
    check("err_after_accept", 32'(err_count), 32'(exp_err));
    check("cmd_ready_after_accept", 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_sweep(input logic [3:0] code, input logic [3:0] exp_bits);
    issue(code, exp_bits, 1'b1);
    sweep_steps(code, exp_bits);
    accept_result(exp_bits == code);
  endtask

  // Pulse reset between edges (we are just after an edge) and release it
  // just after the following edge.
  task automatic reset_pulse(input string tag);
    #3;
    rst = 1'b1;
    #1;
    check_reset_values(tag);
    tick();
    check_reset_values({tag, "_held"});
    rst = 1'b0;
    exp_err = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_err   = 0;
    lu_force  = 1'b0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_func  = 4'd0;
    res_ready = 1'b1;

    // Reset values while rst is high, before any clock edge.
    #2;
    check_reset_values("reset");
    tick();
    rst = 1'b0;

    // AND: first command is accepted on the first edge after release.
    run_sweep(4'b1000, 4'b1000);

    // Fault injection: stuck-at-1 unit, XOR requested.
    lu_force = 1'b1;
    run_sweep(4'b0110, 4'b1111);
    lu_force = 1'b0;

    // Backpressure: result held for 10 cycles while a command waits.
    res_ready = 1'b0;
    issue(4'b0101, 4'b0101, 1'b1);
    sweep_steps(4'b0101, 4'b0101);
    cmd_valid = 1'b1;
    cmd_func  = 4'b1110;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_res_bits", 32'(res_bits), 32'b0101);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_func", 32'(func), 32'b0101);
    end
    res_ready = 1'b1;
    sb_q.push_back({4'b1110, 1'b1, exp_err[7:0]});
    tick();
    check("bp_accept_res_valid", 32'(res_valid), 32'd0);
    check("bp_accept_cmd_ready", 32'(cmd_ready), 32'd1);
    check("bp_pending_not_taken", 32'(func), 32'b0101);
    check("bp_err_unchanged", 32'(err_count), 32'(exp_err));
    tick();
    cmd_valid = 1'b0;
    sweep_steps(4'b1110, 4'b1110);
    accept_result(1'b1);

    // Mid-sweep asynchronous reset in the 2nd SWEEP cycle.
    issue(4'b0011, 4'b0011, 1'b0);
    tick();
    check("mid_sweep_ab", 32'({a, b}), 32'b01);
    reset_pulse("midrst");
    run_sweep(4'b0011, 4'b0011);

    // All 16 codes back-to-back with a correct unit; err_count stays 0.
    for (int c = 0; c < 16; c++) begin
      run_sweep(4'(c), 4'(c));
    end

    // Saturation: start from a clean count, 256 mismatching sweeps.
    reset_pulse("satrst");
    lu_force = 1'b1;
    for (int i = 0; i < 256; i++) begin
      run_sweep(4'b0000, 4'b1111);
    end
    check("sat_final", 32'(err_count), 32'hFF);
    lu_force = 1'b0;

    repeat (3) tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
